// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave: word lengths, FSM states and
// the bit positions of CPOL/CPHA inside the mode field.
package spi_pkg;

  typedef enum logic [1:0] {
    LEN_8  = 2'b00,
    LEN_16 = 2'b01,
    LEN_24 = 2'b10,
    LEN_32 = 2'b11
  } word_len_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10
  } state_e;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  localparam int CNT_W    = 6;

  function automatic logic [CNT_W-1:0] word_bits(input word_len_e len);
    case (len)
      LEN_8:   return 6'd8;
      LEN_16:  return 6'd16;
      LEN_24:  return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

  // Left-justify a right-aligned word so the MSB of every length sits at bit 31.
  function automatic logic [31:0] align_msb(input logic [31:0] data, input word_len_e len);
    case (len)
      LEN_8:   return {data[7:0], 24'h000000};
      LEN_16:  return {data[15:0], 16'h0000};
      LEN_24:  return {data[23:0], 8'h00};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, followed by a
// rising/falling edge detector on the synchronised value.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d_i;
    prev_d    = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, 8/16/24/32-bit words, multiple words per frame.
// The SPI pins are oversampled by the system clock.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCK_i,
  input  logic        CS_i,
  input  logic        MOSI_i,
  output logic        MISO_o,
  output logic        MISO_oe_o,
  input  logic [1:0]  spi_mode_i,
  input  logic [1:0]  word_len_i,
  input  logic [31:0] tx_data_i,
  input  logic        tx_load_i,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  output logic        busy_o,
  output logic        frame_err_o
);

  localparam logic [7:0] SETTLE_CYCLES = 8'(SYNC_STAGES + 1);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk    (CLK),
    .rst    (RST),
    .d_i    (SCK_i),
    .q_o    (sck_q),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk    (CLK),
    .rst    (RST),
    .d_i    (CS_i),
    .q_o    (cs_q),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (CLK),
    .rst    (RST),
    .d_i    (MOSI_i),
    .q_o    (mosi_q),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sync_bits;
  assign unused_sync_bits = sck_q ^ mosi_rise ^ mosi_fall;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  word_len_e         len_q, len_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [31:0]       tx_sr_q, tx_sr_d;
  logic [31:0]       rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        settle_q, settle_d;
  logic              armed_q, armed_d;

  logic              sample_edge;
  logic              shift_edge;
  logic [CNT_W-1:0]  cnt_inc;
  logic [31:0]       rx_shifted;

  // CPOL^CPHA selects which SCK polarity carries the sample edge.
  assign sample_edge = (mode_q[CPOL_BIT] ^ mode_q[CPHA_BIT]) ? sck_fall : sck_rise;
  assign shift_edge  = (mode_q[CPOL_BIT] ^ mode_q[CPHA_BIT]) ? sck_rise : sck_fall;
  assign cnt_inc     = cnt_q + 6'd1;
  assign rx_shifted  = {rx_sr_q[30:0], mosi_q};

  // After reset the CS synchroniser holds a forced 1; only accept a falling
  // edge once the real pin has been seen high, so a CS held low through reset
  // cannot start a frame halfway through a master's transfer.
  always_comb begin
    settle_d = settle_q;
    armed_d  = armed_q;
    if (settle_q != SETTLE_CYCLES) begin
      settle_d = settle_q + 8'd1;
    end else if (cs_q) begin
      armed_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    shadow_d    = shadow_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (tx_load_i) begin
      shadow_d = tx_data_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = ST_LOAD;
          mode_d  = spi_mode_i;
          len_d   = word_len_e'(word_len_i);
        end
      end

      ST_LOAD: begin
        tx_sr_d = align_msb(shadow_q, len_q);
        rx_sr_d = '0;
        cnt_d   = '0;
        state_d = cs_rise ? ST_IDLE : ST_SHIFT;
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          // With a zero count the shift edge is either the first leading edge
          // (CPHA=1) or the trailing edge that closes the previous word
          // (CPHA=0); in both cases the freshly loaded MSB must stay put.
          if (shift_edge && (cnt_q != '0)) begin
            tx_sr_d = {tx_sr_q[30:0], 1'b0};
          end
          if (sample_edge) begin
            rx_sr_d = rx_shifted;
            cnt_d   = cnt_inc;
            if (cnt_inc == word_bits(len_q)) begin
              rx_data_d  = rx_shifted;
              rx_valid_d = 1'b1;
              state_d    = ST_LOAD;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'b00;
      len_q       <= LEN_8;
      shadow_q    <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      shadow_q    <= shadow_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  assign MISO_o      = tx_sr_q[31];
  assign MISO_oe_o   = ~cs_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives the pins and
// every result is compared against hand-computed values.
module tb_spi_slave;

  localparam int HALF = 60;

  logic        CLK;
  logic        RST;
  logic        SCK_i;
  logic        CS_i;
  logic        MOSI_i;
  logic        MISO_o;
  logic        MISO_oe_o;
  logic [1:0]  spi_mode_i;
  logic [1:0]  word_len_i;
  logic [31:0] tx_data_i;
  logic        tx_load_i;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        busy_o;
  logic        frame_err_o;

  int compared   = 0;
  int mismatched = 0;
  int rx_pulses  = 0;
  int err_pulses = 0;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SCK_i       (SCK_i),
    .CS_i        (CS_i),
    .MOSI_i      (MOSI_i),
    .MISO_o      (MISO_o),
    .MISO_oe_o   (MISO_oe_o),
    .spi_mode_i  (spi_mode_i),
    .word_len_i  (word_len_i),
    .tx_data_i   (tx_data_i),
    .tx_load_i   (tx_load_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (rx_valid_o === 1'b1) rx_pulses++;
    if (frame_err_o === 1'b1) err_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One word as an SPI master: nbits clocks, MSB first, MISO captured on the
  // master's sample edge.
  task automatic applyStimulus(input logic [1:0] mode, input int nbits,
                               input logic [31:0] mosi_word, output logic [31:0] miso_word);
    logic cpol;
    logic cpha;
    cpol      = mode[1];
    cpha      = mode[0];
    miso_word = '0;
    if (!cpha) MOSI_i = mosi_word[nbits-1];
    for (int i = nbits - 1; i >= 0; i--) begin
      #HALF;
      if (cpha) MOSI_i = mosi_word[i];
      else      miso_word = {miso_word[30:0], MISO_o};
      SCK_i = ~cpol;
      #HALF;
      if (cpha) miso_word = {miso_word[30:0], MISO_o};
      SCK_i = cpol;
      if (!cpha && i > 0) MOSI_i = mosi_word[i-1];
    end
  endtask

  task automatic load_shadow(input logic [31:0] value);
    @(negedge CLK);
    tx_data_i = value;
    tx_load_i = 1'b1;
    @(negedge CLK);
    tx_load_i = 1'b0;
  endtask

  task automatic select_frame(input logic [1:0] mode, input logic [1:0] len);
    spi_mode_i = mode;
    word_len_i = len;
    SCK_i      = mode[1];
    #(2 * HALF);
    CS_i = 1'b0;
    #(2 * HALF);
  endtask

  task automatic release_frame();
    #HALF;
    CS_i = 1'b1;
    #(2 * HALF);
  endtask

  initial begin
    logic [31:0] got;
    int rx_base;
    int err_base;

    RST        = 1'b1;
    SCK_i      = 1'b0;
    CS_i       = 1'b1;
    MOSI_i     = 1'b0;
    spi_mode_i = 2'b00;
    word_len_i = 2'b00;
    tx_data_i  = '0;
    tx_load_i  = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_miso",      32'(MISO_o),      32'h0);
    checkOutput("rst_miso_oe",   32'(MISO_oe_o),   32'h0);
    checkOutput("rst_busy",      32'(busy_o),      32'h0);
    checkOutput("rst_rx_valid",  32'(rx_valid_o),  32'h0);
    checkOutput("rst_frame_err", 32'(frame_err_o), 32'h0);
    checkOutput("rst_rx_data",   rx_data_o,        32'h0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    $display("[TB] mode 0, 8-bit");
    load_shadow(32'h000000A5);
    rx_base  = rx_pulses;
    err_base = err_pulses;
    select_frame(2'b00, 2'b00);
    checkOutput("m0_busy_in_frame", 32'(busy_o),    32'h1);
    checkOutput("m0_oe_in_frame",   32'(MISO_oe_o), 32'h1);
    checkOutput("m0_miso_preload",  32'(MISO_o),    32'h1);
    applyStimulus(2'b00, 8, 32'h0000003C, got);
    #HALF;
    checkOutput("m0_rx_data",   rx_data_o,                 32'h0000003C);
    checkOutput("m0_rx_pulses", 32'(rx_pulses - rx_base),  32'd1);
    checkOutput("m0_master_rx", got,                       32'h000000A5);
    release_frame();
    checkOutput("m0_busy_after", 32'(busy_o),               32'h0);
    checkOutput("m0_oe_after",   32'(MISO_oe_o),            32'h0);
    checkOutput("m0_no_err",     32'(err_pulses - err_base), 32'd0);

    $display("[TB] mode 3, 32-bit");
    load_shadow(32'hDEADBEEF);
    rx_base = rx_pulses;
    select_frame(2'b11, 2'b11);
    applyStimulus(2'b11, 32, 32'h12345678, got);
    #HALF;
    checkOutput("m3_rx_data",   rx_data_o,                32'h12345678);
    checkOutput("m3_rx_pulses", 32'(rx_pulses - rx_base), 32'd1);
    checkOutput("m3_master_rx", got,                      32'hDEADBEEF);
    release_frame();

    $display("[TB] mode 1, 16-bit, two words per frame");
    load_shadow(32'h00001111);
    rx_base = rx_pulses;
    select_frame(2'b01, 2'b01);
    load_shadow(32'h00002222);
    applyStimulus(2'b01, 16, 32'h0000ABCD, got);
    #HALF;
    checkOutput("m1_w1_master_rx", got,                      32'h00001111);
    checkOutput("m1_w1_rx_data",   rx_data_o,                32'h0000ABCD);
    checkOutput("m1_w1_pulses",    32'(rx_pulses - rx_base), 32'd1);
    applyStimulus(2'b01, 16, 32'h00001357, got);
    #HALF;
    checkOutput("m1_w2_master_rx", got,                      32'h00002222);
    checkOutput("m1_w2_rx_data",   rx_data_o,                32'h00001357);
    checkOutput("m1_w2_pulses",    32'(rx_pulses - rx_base), 32'd2);
    release_frame();

    $display("[TB] mode 2, 24-bit, CS raised after 10 bits");
    rx_base  = rx_pulses;
    err_base = err_pulses;
    select_frame(2'b10, 2'b10);
    applyStimulus(2'b10, 10, 32'h000002AB, got);
    release_frame();
    checkOutput("m2_frame_err",  32'(err_pulses - err_base), 32'd1);
    checkOutput("m2_no_rx",      32'(rx_pulses - rx_base),   32'd0);
    checkOutput("m2_busy_after", 32'(busy_o),                32'h0);
    checkOutput("m2_rx_kept",    rx_data_o,                  32'h00001357);

    $display("[TB] reset in the middle of a frame");
    rx_base  = rx_pulses;
    err_base = err_pulses;
    select_frame(2'b00, 2'b11);
    applyStimulus(2'b00, 5, 32'h0000001F, got);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("mid_rst_miso",      32'(MISO_o),      32'h0);
    checkOutput("mid_rst_miso_oe",   32'(MISO_oe_o),   32'h0);
    checkOutput("mid_rst_busy",      32'(busy_o),      32'h0);
    checkOutput("mid_rst_rx_valid",  32'(rx_valid_o),  32'h0);
    checkOutput("mid_rst_frame_err", 32'(frame_err_o), 32'h0);
    checkOutput("mid_rst_rx_data",   rx_data_o,        32'h0);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    checkOutput("post_rst_idle", 32'(busy_o), 32'h0);
    release_frame();
    checkOutput("post_rst_no_err", 32'(err_pulses - err_base), 32'd0);
    checkOutput("post_rst_no_rx",  32'(rx_pulses - rx_base),   32'd0);
    load_shadow(32'h0000005A);
    select_frame(2'b00, 2'b00);
    applyStimulus(2'b00, 8, 32'h000000C3, got);
    #HALF;
    checkOutput("post_rst_rx_data",   rx_data_o,                32'h000000C3);
    checkOutput("post_rst_master_rx", got,                      32'h0000005A);
    checkOutput("post_rst_pulses",    32'(rx_pulses - rx_base), 32'd1);
    release_frame();

    $display("[TB] mode and length changed during a frame");
    load_shadow(32'h00000096);
    rx_base = rx_pulses;
    select_frame(2'b00, 2'b00);
    spi_mode_i = 2'b11;
    word_len_i = 2'b11;
    applyStimulus(2'b00, 8, 32'h00000069, got);
    #HALF;
    checkOutput("latch_rx_data",   rx_data_o,                32'h00000069);
    checkOutput("latch_master_rx", got,                      32'h00000096);
    checkOutput("latch_pulses",    32'(rx_pulses - rx_base), 32'd1);
    release_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for SCK_i, CS_i and MOSI_i.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port SCK_i  input  1  SPI serial clock from master; asynchronous to CLK.
REQ-005 SHALL have port CS_i  input  1  chip select, active-low; asynchronous to CLK.
REQ-006 SHALL have port MOSI_i  input  1  serial data from master; asynchronous to CLK.
REQ-007 SHALL have port MISO_o  output  1  serial data to master.
REQ-008 SHALL have port MISO_oe_o  output  1  MISO drive enable; high only while selected.
REQ-009 SHALL have port spi_mode_i  input  2  {CPOL,CPHA}.
REQ-010 SHALL have port word_len_i  input  2  00=8, 01=16, 10=24, 11=32 bits.
REQ-011 SHALL have port tx_data_i  input  32  next response word, right-aligned.
REQ-012 SHALL have port tx_load_i  input  1  one-cycle strobe; writes tx_data_i into the shadow register.
REQ-013 SHALL have port rx_data_o  output  32  last complete received word, right-aligned, zero-extended.
REQ-014 SHALL have port rx_valid_o  output  1  one-cycle pulse; rx_data_o updated.
REQ-015 SHALL have port busy_o  output  1  high while a frame is in progress.
REQ-016 SHALL have port frame_err_o  output  1  one-cycle pulse; CS_i deasserted mid-word.

Function
REQ-017 SHALL synchronise SCK_i, CS_i and MOSI_i through SYNC_STAGES flops, then detect edges on the synchronised SCK and CS; SCK_i frequency SHALL NOT exceed CLK/8.
REQ-018 SHALL implement states IDLE, LOAD, SHIFT.
- IDLE -> LOAD on synchronised CS falling edge.
- LOAD -> SHIFT after one cycle.
- SHIFT -> LOAD on word completion while CS is low.
- SHIFT -> IDLE on CS rising edge.
REQ-019 SHALL latch spi_mode_i and word_len_i on the CS falling edge; changes during the frame SHALL be ignored.
REQ-020 In LOAD, SHALL copy the shadow register to the TX shift register and reset the bit counter to 0.
REQ-021 SHALL treat the leading SCK edge as the sample edge when CPHA=0 and the trailing edge when CPHA=1; the other edge SHALL be the shift edge. Leading edge = rising when CPOL=0, falling when CPOL=1.
REQ-022 SHALL transfer MSB first: bit (N-1) of the word first, where N is the latched word length.
REQ-023 CPHA=0: MISO_o SHALL present bit N-1 from LOAD onward and advance on each shift edge.
REQ-024 CPHA=1: MISO_o SHALL advance on each shift edge, starting from bit N-1 at the first leading edge.
REQ-025 SHALL shift MOSI into the RX register on each sample edge and increment the bit counter.
REQ-026 When the counter reaches N, SHALL update rx_data_o (upper 32-N bits zero) and pulse rx_valid_o 1 cycle, within 2 CLK cycles of the synchronised sample edge.
REQ-027 Multiple words per CS-low frame SHALL be supported; each word boundary reloads from the shadow register.
REQ-028 If tx_load_i is not strobed between words, the previous shadow value SHALL be resent.
REQ-029 tx_load_i coincident with LOAD SHALL be written to the shadow register but not used until the next word.
REQ-030 CS rising edge with counter != 0 SHALL pulse frame_err_o, discard the partial word, not pulse rx_valid_o, and return to IDLE.
REQ-031 CS rising edge with counter == 0 SHALL return to IDLE silently.
REQ-032 busy_o SHALL be high in LOAD and SHIFT; MISO_oe_o SHALL equal the synchronised, inverted CS.
REQ-033 SCK edges while in IDLE SHALL be ignored.

Reset
REQ-034 While RST is high, SHALL set: state=IDLE; MISO_o=0; MISO_oe_o=0; busy_o=0; rx_valid_o=0; frame_err_o=0; rx_data_o=0; shadow=0; counter=0; synchronisers to CS=1 and SCK=0.
REQ-035 Reset asserted mid-frame SHALL abort without pulsing frame_err_o; after release the block waits for a fresh CS falling edge.

Structure
REQ-036 spi_pkg SHALL hold: word-length enum and decode function (to 8/16/24/32), state enum, and the mode field positions CPOL=bit1, CPHA=bit0.
REQ-037 SHALL instantiate sub-module spi_sync_edge (synchroniser plus rise/fall detector) once per input.

Verification
REQ-038 Mode 0, 8-bit, shadow=0xA5, master sends 0x3C -> rx_data_o=0x0000003C with one rx_valid_o pulse; master receives 0xA5.
REQ-039 Mode 3, 32-bit, shadow=0xDEADBEEF, master sends 0x12345678 -> rx_data_o=0x12345678; master receives 0xDEADBEEF.
REQ-040 Mode 1, 16-bit, two words in one frame, shadow 0x1111 then tx_load_i 0x2222 during word 1 -> master receives 0x1111 then 0x2222; two rx_valid_o pulses.
REQ-041 Mode 2, 24-bit, CS raised after 10 bits -> frame_err_o pulses once; rx_valid_o stays 0; busy_o falls.
REQ-042 RST asserted mid-frame (mode 0, 32-bit, after 5 bits) -> all outputs at reset values the next cycle; no frame_err_o; the next frame is received correctly.
REQ-043 spi_mode_i changed from 0 to 3 mid-frame -> transfer completes in mode 0.
